edge_event_collector: RTL

- Synchronous consumer of mixed-edge stimulus: one level-change source (a), one rising-edge source (b), one falling-edge source (c).
- Synchronises the three asynchronous inputs and detects their events. Mirrors the event-driven toggle as a registered output.
- Time-stamps each event cycle and queues it in a small FIFO drained over a valid/ready interface, for coverage checks of edge-sensitive logic.

---
 rtl/edge_event_collector_pkg.sv | 26 ++
 rtl/edge_event_collector_fifo.sv | 68 ++++++
 rtl/edge_event_collector.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/edge_event_collector_pkg.sv
// ---------------------------------------------------------------------------
// edge_event_pkg
// Shared definitions for the edge event collector:
//   - bit positions of each source inside the event mask
//   - default event record layout {mask, ts}
//   - number of post-reset warm-up cycles during which events are ignored
// ---------------------------------------------------------------------------
package edge_event_pkg;

   localparam int EVT_A    = 2;   // a_in level change
   localparam int EVT_B    = 1;   // b_in rising edge
   localparam int EVT_C    = 0;   // c_in falling edge
   localparam int MASK_W   = 3;
   localparam int TS_W_DEF = 8;

   // Cycles needed after reset release before the prev flops hold real levels.
   localparam logic [1:0] WARMUP = 2'd3;

   // Event record at the default timestamp width; the top builds the same
   // {mask, ts} layout at whatever TS_W it is given.
   typedef struct packed {
      logic [MASK_W-1:0]   mask;
      logic [TS_W_DEF-1:0] ts;
   } evt_rec_t;

endpackage

// File: rtl/edge_event_collector_fifo.sv
// ---------------------------------------------------------------------------
// evt_fifo
// Synchronous FIFO with count-based full/empty and flop-held head data.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (flushes FIFO)
//   i_push, i_data    write request and record
//   i_pop             read request (ignored when empty)
//   o_valid, o_data   head valid / head record
//   o_drop            push rejected this cycle (full and no pop)
// ---------------------------------------------------------------------------
module evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_count;

   logic w_full;
   logic w_empty;
   logic w_pop;
   logic w_push;

   assign w_full  = (r_count == OCC_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = i_pop & ~w_empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push  = i_push & (~w_full | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + OCC_W'(1);
            2'b01:   r_count <= r_count - OCC_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_valid = ~w_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_drop  = i_push & w_full & ~w_pop;

endmodule

// File: rtl/edge_event_collector.sv
// ---------------------------------------------------------------------------
// edge_event_collector
// Synchronises three asynchronous sources, detects a change on a_in, a rising
// edge on b_in and a falling edge on c_in, and queues a time-stamped record of
// every event cycle into a FIFO drained over valid/ready.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   a_in, b_in, c_in         asynchronous event sources
//   out_valid/out_ready      head handshake
//   out_mask, out_ts         head record {a_chg, b_rise, c_fall}, timestamp
//   toggle_q                 inverts once per event cycle
//   a_cnt, b_cnt, c_cnt      saturating per-source event counters
//   ovf, ovf_clr             sticky drop flag and its synchronous clear
// ---------------------------------------------------------------------------
module edge_event_collector
   import edge_event_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TS_W  = TS_W_DEF,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_in,
   input  logic              b_in,
   input  logic              c_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MASK_W-1:0] out_mask,
   output logic [TS_W-1:0]   out_ts,
   output logic              toggle_q,
   output logic [CNT_W-1:0]  a_cnt,
   output logic [CNT_W-1:0]  b_cnt,
   output logic [CNT_W-1:0]  c_cnt,
   output logic              ovf,
   input  logic              ovf_clr
);

   localparam int REC_W = MASK_W + TS_W;

   typedef struct packed {
      logic [MASK_W-1:0] mask;
      logic [TS_W-1:0]   ts;
   } rec_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      if (en && (v != '1)) return v + CNT_W'(1);
      return v;
   endfunction

   logic [MASK_W-1:0] w_in;
   logic [MASK_W-1:0] r_s1;
   logic [MASK_W-1:0] r_s2;
   logic [MASK_W-1:0] r_p;
   logic [1:0]        r_wu;
   logic [TS_W-1:0]   r_ts;
   logic              r_toggle;
   logic [CNT_W-1:0]  r_a_cnt;
   logic [CNT_W-1:0]  r_b_cnt;
   logic [CNT_W-1:0]  r_c_cnt;
   logic              r_ovf;

   logic [MASK_W-1:0] w_mask;
   logic              w_evt;
   rec_t              w_rec;
   rec_t              w_head;
   logic [REC_W-1:0]  w_head_bits;
   logic              w_drop;

   always_comb begin
      w_in        = '0;
      w_in[EVT_A] = a_in;
      w_in[EVT_B] = b_in;
      w_in[EVT_C] = c_in;
   end

   // Stage: two-flop synchroniser, then previous-value flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_p  <= '0;
         r_wu <= '0;
         r_ts <= '0;
      end else begin
         r_s1 <= w_in;
         r_s2 <= r_s1;
         r_p  <= r_s2;
         if (r_wu != WARMUP) r_wu <= r_wu + 2'd1;
         r_ts <= r_ts + TS_W'(1);
      end
   end

   // Until r_p has loaded a real level it still holds the reset 0, which would
   // turn an input sitting at 1 into a false change/rise.
   always_comb begin
      w_mask = '0;
      if (r_wu == WARMUP) begin
         w_mask[EVT_A] = r_s2[EVT_A] ^ r_p[EVT_A];
         w_mask[EVT_B] = r_s2[EVT_B] & ~r_p[EVT_B];
         w_mask[EVT_C] = ~r_s2[EVT_C] & r_p[EVT_C];
      end
   end

   assign w_evt      = |w_mask;
   assign w_rec.mask = w_mask;
   assign w_rec.ts   = r_ts;

   // Stage: event bookkeeping; dropped records still count and toggle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_toggle <= 1'b0;
         r_a_cnt  <= '0;
         r_b_cnt  <= '0;
         r_c_cnt  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_evt) r_toggle <= ~r_toggle;
         r_a_cnt <= sat_inc(r_a_cnt, w_mask[EVT_A]);
         r_b_cnt <= sat_inc(r_b_cnt, w_mask[EVT_B]);
         r_c_cnt <= sat_inc(r_c_cnt, w_mask[EVT_C]);
         if (w_drop)       r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   end

   evt_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_evt),
      .i_data  (w_rec),
      .i_pop   (out_ready),
      .o_valid (out_valid),
      .o_data  (w_head_bits),
      .o_drop  (w_drop)
   );

   assign w_head   = rec_t'(w_head_bits);
   assign out_mask = w_head.mask;
   assign out_ts   = w_head.ts;
   assign toggle_q = r_toggle;
   assign a_cnt    = r_a_cnt;
   assign b_cnt    = r_b_cnt;
   assign c_cnt    = r_c_cnt;
   assign ovf      = r_ovf;

endmodule
